// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-extraction pipeline.
package imm_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int XLEN_32     = 32;
   localparam int XLEN_64     = 64;

   typedef enum logic [2:0] {
      SEL_I  = 3'd0,
      SEL_S  = 3'd1,
      SEL_B  = 3'd2,
      SEL_J  = 3'd3,
      SEL_U  = 3'd4,
      SEL_SH = 3'd5
   } imm_sel_t;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == XLEN_32) || (xlen == XLEN_64);
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate decode: sign-extended formats, a zero-extended
// shift amount, and an error flag for the two unassigned selector codes.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [INSTR_WIDTH-1:7] instr,
   input  logic [2:0]             sel,
   output logic [XLEN-1:0]        imm,
   output logic                   err
);

   // RV64 shifts take a 6-bit amount, RV32 a 5-bit one.
   localparam int SHW = (XLEN == XLEN_64) ? 6 : 5;

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_extract: XLEN must be 32 or 64");
   end

   logic [31:0] imm32;
   logic        sext;

   always_comb begin
      imm32 = '0;
      sext  = 1'b1;
      err   = 1'b0;
      case (sel)
         SEL_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         SEL_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         SEL_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         SEL_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         SEL_U:   imm32 = {instr[31:12], 12'b0};
         SEL_SH:  sext  = 1'b0;
         default: begin
            sext = 1'b0;
            err  = 1'b1;
         end
      endcase
   end

   always_comb begin
      imm = '0;
      if (sext) begin
         imm        = {XLEN{imm32[31]}};
         imm[31:0]  = imm32;
      end else if (!err) begin
         imm[SHW-1:0] = instr[20+SHW-1:20];
      end
   end

endmodule

// File: rtl/imm_pipe.sv
// Valid/ready wrapper around imm_extract: a main output slot plus a skid slot,
// so in_ready can be a flop with no combinational path from out_ready.
module imm_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:7] in_instr,
   input  logic [2:0]             in_sel,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_imm,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_err
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } slot_t;

   logic [XLEN-1:0] dec_imm;
   logic            dec_err;
   slot_t           dec, main_q, skid_q;
   logic            main_valid, skid_valid;
   logic            accept;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr (in_instr),
      .sel   (in_sel),
      .imm   (dec_imm),
      .err   (dec_err)
   );

   always_comb begin
      dec     = '0;
      dec.imm = dec_imm;
      dec.tag = in_tag;
      dec.err = dec_err;
   end

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;

   // Skid is only ever full while main is full, so draining skid keeps main valid.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (skid_valid) begin
         if (out_ready) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!main_valid || out_ready) begin
            main_q     <= dec;
            main_valid <= 1'b1;
         end else begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
         end
      end else if (out_ready) begin
         main_valid <= 1'b0;
      end
   end

   assign out_valid = main_valid;
   assign out_imm   = main_q.imm;
   assign out_tag   = main_q.tag;
   assign out_err   = main_q.err;

endmodule

// File: tb/tb_imm_pipe.sv
// Bench for imm_pipe: directed decode/backpressure/reset cases plus a random
// valid/ready stream scored against an arithmetic reference model.
module tb_imm_pipe;
   import imm_pkg::*;

   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [31:0]   instr = '0;
   logic [2:0]    sel = '0;
   logic [TW-1:0] tag = '0;

   logic          in_ready, out_valid, out_err;
   logic [31:0]   out_imm;
   logic [TW-1:0] out_tag;
   logic          in_ready64, out_valid64, out_err64;
   logic [63:0]   out_imm64;
   logic [TW-1:0] out_tag64;

   imm_pipe #(.XLEN(32), .TAG_W(TW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(instr[31:7]), .in_sel(sel), .in_tag(tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
   );

   imm_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(instr[31:7]), .in_sel(sel), .in_tag(tag), .out_valid(out_valid64),
      .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Immediate value from the format rules, built with integer arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] i, input int s, input int xlen);
      longint v;
      case (s)
         0: begin v = longint'(i[31:20]); if (v >= 2048) v -= 4096; end
         1: begin v = longint'(i[31:25]) * 32 + longint'(i[11:7]); if (v >= 2048) v -= 4096; end
         2: begin
            v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            if (v >= 4096) v -= 8192;
         end
         3: begin
            v = longint'(i[31]) * (64'sd1 << 20) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            if (v >= (64'sd1 << 20)) v -= (64'sd1 << 21);
         end
         4: begin v = longint'(i[31:12]) * 4096; if (i[31]) v -= (64'sd1 << 32); end
         5: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
         default: v = 0;
      endcase
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return 64'(v);
   endfunction

   typedef struct {
      logic [63:0]   i32;
      logic [63:0]   i64;
      logic [TW-1:0] tag;
      logic          err;
   } exp_t;

   exp_t          q[$];
   int            seen[$];
   logic          hold = 1'b0;
   logic [31:0]   h_imm;
   logic [63:0]   h_imm64;
   logic [TW-1:0] h_tag;
   logic          h_err;

   // Scoreboard: inputs are stable around the negedge, so handshakes seen here
   // are the ones the next rising edge will perform.
   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_imm", 64'(out_imm), 64'(h_imm));
            chk("hold_imm64", out_imm64, h_imm64);
            chk("hold_tag", 64'(out_tag), 64'(h_tag));
            chk("hold_err", 64'(out_err), 64'(h_err));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 64'(out_tag), 64'h1_0000);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_imm32", 64'(out_imm), e.i32);
               chk("sb_imm64", out_imm64, e.i64);
               chk("sb_tag", 64'(out_tag), 64'(e.tag));
               chk("sb_err", 64'(out_err), 64'(e.err));
               seen.push_back(int'(out_tag));
            end
         end
         if (in_valid && in_ready) begin
            exp_t n;
            n.i32 = ref_imm(instr, int'(sel), 32);
            n.i64 = ref_imm(instr, int'(sel), 64);
            n.tag = tag;
            n.err = (sel >= 3'd6);
            q.push_back(n);
         end
         hold    = out_valid && !out_ready;
         h_imm   = out_imm;
         h_imm64 = out_imm64;
         h_tag   = out_tag;
         h_err   = out_err;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] vec_i [5] = '{32'hFFF00093, 32'hFE20AC23, 32'hFE000EE3, 32'h0080006F, 32'h123450B7};
   logic [31:0] vec_e [5] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000008, 32'h12345000};

   initial begin
      int acc;
      int cyc;

      repeat (2) step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      reset_n = 1'b1;

      // Back-to-back decode vectors, one per cycle.
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         instr    = vec_i[k];
         sel      = 3'(k);
         tag      = TW'(k + 8);
         step();
         chk($sformatf("dec_valid_%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("dec_imm_%0d", k), 64'(out_imm), 64'(vec_e[k]));
         chk($sformatf("dec_tag_%0d", k), 64'(out_tag), 64'(k + 8));
         chk($sformatf("dec_ready_%0d", k), 64'(in_ready), 64'd1);
         if (k == 0) chk("dec64_I", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      instr = 32'h03F09093; sel = 3'd5; tag = 5'd9;
      step();
      chk("sh64", out_imm64, 64'h3F);
      chk("sh32", 64'(out_imm), 64'h1F);
      instr = 32'hFFF00093; sel = 3'd7; tag = 5'd3;
      step();
      chk("ill_imm", 64'(out_imm), 64'd0);
      chk("ill_err", 64'(out_err), 64'd1);
      chk("ill_tag", 64'(out_tag), 64'd3);
      in_valid = 1'b0;
      step();
      seen.delete();

      // Backpressure: tags 1,2 fill main and skid, tag 3 must wait.
      out_ready = 1'b0;
      in_valid = 1'b1; sel = 3'd0;
      tag = 5'd1; instr = $urandom; step();
      tag = 5'd2; instr = $urandom; step();
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      tag = 5'd3; instr = $urandom; step();
      chk("bp_ready_held", 64'(in_ready), 64'd0);
      chk("bp_main_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 10 && !in_ready; c++) step();
      chk("bp_ready_back", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      chk("bp_count", 64'(seen.size()), 64'd3);
      for (int k = 0; k < 3 && k < seen.size(); k++)
         chk($sformatf("bp_order_%0d", k), 64'(seen[k]), 64'(k + 1));

      // Reset with both slots full.
      out_ready = 1'b0;
      in_valid = 1'b1;
      tag = 5'd4; instr = $urandom; step();
      tag = 5'd5; instr = $urandom; step();
      chk("mr_full", 64'(in_ready), 64'd0);
      reset_n = 1'b0; tag = 5'd6; step();
      reset_n = 1'b1; in_valid = 1'b0;
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_in_ready", 64'(in_ready), 64'd1);
      chk("mr_out_tag", 64'(out_tag), 64'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("mr_no_stale", 64'(out_valid), 64'd0);
      end

      // Random streaming.
      acc = 0;
      cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         instr     = $urandom;
         sel       = 3'($urandom_range(0, 7));
         tag       = TW'($urandom);
         if (in_valid && in_ready) acc++;
         step();
         cyc++;
      end
      chk("rand_accepts", 64'(acc), 64'd1000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("rand_drained", 64'(q.size()), 64'd0);
      chk("rand_idle", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
